// File: rtl/md_issue_ctrl_if.sv
// Requester <-> controller <-> HI/LO unit signal bundle for md_issue_ctrl.
// The slave modport is the controller's view; the master modport is the
// environment's view (pipeline request side plus the unit's HI/LO outputs).
interface md_issue_ctrl_if #(
  parameter int CNT_W = 4
) ();
  // pipeline request side
  logic              req_valid;
  logic [3:0]        req_op;
  logic [31:0]       req_a;
  logic [31:0]       req_b;
  logic              req_ready;
  logic              stall;
  logic              flush;
  // unit side
  logic [2:0]        md_aluop;
  logic [31:0]       md_a;
  logic [31:0]       md_b;
  logic              md_lock;
  logic [31:0]       md_hi;
  logic [31:0]       md_lo;
  // readback / status
  logic              rd_valid;
  logic [31:0]       rd_data;
  logic [CNT_W-1:0]  busy_cnt;

  modport slave (
    input  req_valid, req_op, req_a, req_b, flush, md_hi, md_lo,
    output req_ready, stall, md_aluop, md_a, md_b, md_lock,
           rd_valid, rd_data, busy_cnt
  );

  modport master (
    output req_valid, req_op, req_a, req_b, flush, md_hi, md_lo,
    input  req_ready, stall, md_aluop, md_a, md_b, md_lock,
           rd_valid, rd_data, busy_cnt
  );
endinterface

// File: rtl/md_issue_ctrl.sv
// E-stage requester for the HI/LO multiply/divide unit.
// Issues ops to the unit, mirrors its busy countdown, stalls HI/LO accesses
// until results are valid, returns mfhi/mflo data and locks the unit on flush.
module md_issue_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 4   // must match the interface CNT_W and hold max latency
) (
  input  logic           clk,
  input  logic           reset,
  md_issue_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_LAT);
  localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_LAT);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_busy_cnt, w_busy_nxt;
  logic             r_rd_valid;
  logic [31:0]      r_rd_data;

  logic w_hl_op, w_is_mul, w_is_div, w_is_mt, w_is_rd;
  logic w_idle, w_ready, w_fire, w_issue;

  // Opcode decode: which codes touch HI/LO and which class they belong to.
  always_comb begin
    w_is_mul = 1'b0;
    w_is_div = 1'b0;
    w_is_mt  = 1'b0;
    w_is_rd  = 1'b0;
    unique case (bus.req_op)
      4'd1, 4'd2: w_is_mul = 1'b1;
      4'd3, 4'd4: w_is_div = 1'b1;
      4'd5, 4'd6: w_is_mt  = 1'b1;
      4'd8, 4'd9: w_is_rd  = 1'b1;
      default: ;
    endcase
  end

  assign w_hl_op = w_is_mul | w_is_div | w_is_mt | w_is_rd;
  assign w_idle  = (r_state == ST_IDLE);

  // Non-HI/LO codes never wait on the unit; flush and reset kill acceptance.
  assign w_ready = ~reset & ~bus.flush & (~w_hl_op | w_idle);
  assign w_fire  = bus.req_valid & w_ready;
  assign w_issue = w_fire & (w_is_mul | w_is_div | w_is_mt);

  // Unit-facing drive: opcode only in the accepted cycle, lock mirrors flush.
  assign bus.md_aluop  = w_issue ? bus.req_op[2:0] : 3'd0;
  assign bus.md_a      = bus.req_a;
  assign bus.md_b      = bus.req_b;
  assign bus.md_lock   = bus.flush;
  assign bus.req_ready = w_ready;
  assign bus.stall     = ~reset & bus.req_valid & ~w_ready & ~bus.flush;
  assign bus.busy_cnt  = r_busy_cnt;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.rd_data   = r_rd_data;

  // Next busy count / state: load on issue, count down, freeze while locked.
  always_comb begin
    w_state_nxt = r_state;
    w_busy_nxt  = r_busy_cnt;
    if (bus.flush) begin
      // unit is locked, its counter does not move, so neither does ours
      w_state_nxt = r_state;
      w_busy_nxt  = r_busy_cnt;
    end else if (w_issue && w_is_mul) begin
      w_busy_nxt  = MUL_LD;
      w_state_nxt = ST_MUL;
    end else if (w_issue && w_is_div) begin
      w_busy_nxt  = DIV_LD;
      w_state_nxt = ST_DIV;
    end else if (r_busy_cnt != '0) begin
      w_busy_nxt = r_busy_cnt - 1'b1;
    end
    // a zero count always means results are readable
    if (w_busy_nxt == '0) w_state_nxt = ST_IDLE;
  end

  // State and busy mirror register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_busy_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy_cnt <= w_busy_nxt;
    end
  end

  // mfhi/mflo capture: data registered on accept, valid pulses one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_fire & w_is_rd;
      if (w_fire && w_is_rd)
        r_rd_data <= (bus.req_op == 4'd8) ? bus.md_hi : bus.md_lo;
    end
  end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: directed scenarios followed by random traffic,
// with a behavioural model of both the controller rules and the HI/LO unit.
module tb_md_issue_ctrl;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
  localparam int CNT_W   = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_issue_ctrl_if #(.CNT_W(CNT_W)) bus ();

  md_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // model state
  int          m_busy;
  logic        m_rdv;
  logic [31:0] m_rdd;
  logic [31:0] m_hi, m_lo;
  bit          m_init = 0;
  int          stall_seen, busy_seen;
  logic        last_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive, check, clock, advance the model.
  task automatic step(input logic v, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic fl, input logic rst);
    bit hl, e_ready, iss, rd;
    logic [2:0] e_aluop;
    longint sa, sb;
    logic [63:0] p;
    int ia, ib;
    bus.req_valid = v; bus.req_op = op; bus.req_a = a; bus.req_b = b;
    bus.flush = fl; reset = rst;
    #1;
    hl      = (op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9});
    e_ready = !rst && !fl && (!hl || m_busy == 0);
    iss     = v && e_ready && (op >= 4'd1) && (op <= 4'd6);
    rd      = v && e_ready && (op == 4'd8 || op == 4'd9);
    e_aluop = iss ? op[2:0] : 3'd0;
    chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
    chk("md_aluop",  32'(bus.md_aluop),  32'(e_aluop));
    chk("stall",     32'(bus.stall),     32'(!rst && v && !e_ready && !fl));
    chk("md_lock",   32'(bus.md_lock),   32'(fl));
    chk("md_a",      bus.md_a, a);
    chk("md_b",      bus.md_b, b);
    if (m_init) begin
      chk("busy_cnt", 32'(bus.busy_cnt), 32'(m_busy));
      chk("rd_valid", 32'(bus.rd_valid), 32'(m_rdv));
      chk("rd_data",  bus.rd_data, m_rdd);
    end
    if (bus.stall === 1'b1) stall_seen++;
    if (bus.busy_cnt !== '0) busy_seen++;
    last_ready = bus.req_ready;
    @(posedge clk); #1;
    if (rst) begin
      m_busy = 0; m_rdv = 0; m_rdd = '0; m_hi = '0; m_lo = '0; m_init = 1;
    end else begin
      m_rdv = rd;
      if (rd) m_rdd = (op == 4'd8) ? m_hi : m_lo;
      if (!fl) begin
        if (iss && (op == 4'd1 || op == 4'd2))      m_busy = MUL_LAT;
        else if (iss && (op == 4'd3 || op == 4'd4)) m_busy = DIV_LAT;
        else if (m_busy > 0)                        m_busy--;
      end
      // unit model: results computed at issue; reads are gated by the busy window
      if (iss) begin
        ia = a; ib = b;
        case (op)
          4'd1: begin sa = longint'(ia); sb = longint'(ib); p = 64'(sa * sb); {m_hi, m_lo} = p; end
          4'd2: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; end
          4'd3: begin m_lo = ia / ib; m_hi = ia % ib; end
          4'd4: begin m_lo = a / b;   m_hi = a % b;   end
          4'd5: m_hi = a;
          4'd6: m_lo = a;
          default: ;
        endcase
      end
    end
    bus.md_hi = m_hi; bus.md_lo = m_lo;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic v, fl, rst;
    logic [3:0] op;
    logic [31:0] a, b;
    m_busy = 0; m_rdv = 0; m_rdd = '0; m_hi = '0; m_lo = '0;
    bus.md_hi = '0; bus.md_lo = '0;
    bus.req_valid = 0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0; bus.flush = 0;
    reset = 1;
    @(negedge clk);
    step(1'b1, 4'd1, 32'd1, 32'd1, 1'b0, 1'b1);   // request during reset must not issue
    step(1'b1, 4'd5, 32'd2, 32'd0, 1'b0, 1'b1);
    chk("rst_busy", 32'(bus.busy_cnt), 32'd0);
    chk("rst_rdv",  32'(bus.rd_valid), 32'd0);
    chk("rst_rdd",  bus.rd_data, 32'd0);

    // 1: mult -3*7, countdown 5..0, then mflo / mfhi
    step(1'b1, 4'd1, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0);
    chk("t1_cnt5", 32'(bus.busy_cnt), 32'd5);
    idle(5);
    chk("t1_cnt0", 32'(bus.busy_cnt), 32'd0);
    step(1'b1, 4'd9, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("t1_lo", bus.rd_data, 32'hFFFF_FFEB);
    step(1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("t1_hi", bus.rd_data, 32'hFFFF_FFFF);

    // 2: divu 100/7 then mfhi next cycle: 10 stall cycles, HI=2, LO=14
    step(1'b1, 4'd4, 32'd100, 32'd7, 1'b0, 1'b0);
    stall_seen = 0;
    for (int i = 0; i < 30 && !(last_ready === 1'b1 && bus.req_op == 4'd8); i++)
      step(1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("t2_stalls", 32'(stall_seen), 32'd10);
    chk("t2_hi", bus.rd_data, 32'd2);
    step(1'b1, 4'd9, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("t2_lo", bus.rd_data, 32'd14);

    // 3: div in flight, flush 3 cycles at busy 6: counter freezes, 13 busy cycles
    step(1'b1, 4'd3, 32'd50, 32'd5, 1'b0, 1'b0);
    busy_seen = 0; stall_seen = 0;
    for (int i = 0; i < 4; i++) step(1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("t3_at6", 32'(bus.busy_cnt), 32'd6);
    for (int i = 0; i < 3; i++) step(1'b1, 4'd8, 32'd0, 32'd0, 1'b1, 1'b0);
    chk("t3_hold6", 32'(bus.busy_cnt), 32'd6);
    for (int i = 0; i < 30 && bus.busy_cnt != '0; i++)
      step(1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("t3_busy_total", 32'(busy_seen), 32'd13);
    chk("t3_stalls", 32'(stall_seen), 32'd10);
    step(1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("t3_hi", bus.rd_data, 32'd0);

    // 4: flushed mthi is dropped; HI keeps previous value (0)
    step(1'b1, 4'd5, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);
    step(1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("t4_hi", bus.rd_data, 32'd0);

    // 5: reset mid-mult clears everything, mthi accepted right after
    step(1'b1, 4'd1, 32'd3, 32'd3, 1'b0, 1'b0);
    idle(1);
    chk("t5_at4", 32'(bus.busy_cnt), 32'd4);
    step(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    chk("t5_busy", 32'(bus.busy_cnt), 32'd0);
    chk("t5_rdv", 32'(bus.rd_valid), 32'd0);
    step(1'b1, 4'd5, 32'h55, 32'd0, 1'b0, 1'b0);
    chk("t5_ready", 32'(last_ready), 32'd1);

    // 6: mthi then mfhi back-to-back, no stall
    stall_seen = 0;
    step(1'b1, 4'd5, 32'h1234, 32'd0, 1'b0, 1'b0);
    step(1'b1, 4'd8, 32'd0, 32'd0, 1'b0, 1'b0);
    chk("t6_rdv", 32'(bus.rd_valid), 32'd1);
    chk("t6_hi", bus.rd_data, 32'h1234);
    chk("t6_stalls", 32'(stall_seen), 32'd0);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      op  = 4'($urandom_range(0, 15));
      a   = $urandom;
      b   = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(1, 20));
      if (b == 32'd0) b = 32'd1;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      fl  = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 59) == 0);
      step(v, op, a, b, fl, rst);
    end
    idle(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
